// File: rtl/slt_compare_pipe.sv
// -----------------------------------------------------------------------------
// slt_compare_pipe
//
// Purpose:
//   Two-stage pipelined set-less-than unit for the CPU execute stage.
//   Handles SLT, SLTU, SLTI and SLTIU. Immediates are sign-extended from
//   IMM_W bits to WIDTH bits, including for SLTIU, which then compares
//   unsigned. The result is {WIDTH-1 zeros, lt}. Latency is 2 cycles and
//   throughput is 1 op/cycle while the consumer keeps out_ready high.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid & ready are both 1.
//   A producer holds valid and its payload until the transfer happens.
//   This unit holds out_valid and out_result stable while out_ready is low.
//   in_ready is combinational from the pipeline occupancy, out_ready, flush
//   and rst. in_ready never depends on in_valid.
//
// Ports:
//   clk         clock. All state changes on the rising edge.
//   rst         synchronous active-high reset. Overrides flush and handshakes.
//   flush       synchronous kill of every in-flight op. No accept that cycle.
//   in_valid    an op is offered this cycle.
//   in_ready    the unit accepts the offered op this cycle.
//   in_op       00 SLT, 01 SLTU, 10 SLTI, 11 SLTIU.
//   in_a        rs operand.
//   in_b        rt operand. Used only by op 0x.
//   in_imm      immediate. Used only by op 1x.
//   out_valid   out_result holds a live result.
//   out_ready   the consumer takes the result this cycle.
//   out_result  {WIDTH-1 zeros, lt}.
// -----------------------------------------------------------------------------
module slt_compare_pipe #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [IMM_W-1:0] in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
);

   // Stage 1 registers: operands after operand select, plus the compare mode.
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_signed;

   logic             s2_adv;
   logic             s1_adv;
   logic             accept;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] b_eff;
   logic             op_signed;
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             lt;

   // ---------------------------------------------------------------------------
   // Advance and accept
   // ---------------------------------------------------------------------------
   // S2 drains whenever it is empty or its result is taken. S1 moves into S2
   // under the same condition, so a full pipeline can pop and push at once.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s2_adv;
   assign in_ready = (!s1_valid || s1_adv) && !flush && !rst;
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------------------
   // Operand select
   // ---------------------------------------------------------------------------
   // The sized cast of a signed value sign-extends. It also works when
   // IMM_W == WIDTH, where an explicit replication would have zero width.
   assign imm_ext   = WIDTH'($signed(in_imm));
   assign b_eff     = in_op[1] ? imm_ext : in_b;
   assign op_signed = !in_op[0];

   // ---------------------------------------------------------------------------
   // Stage 1
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_adv || !s1_valid) begin
         // S1 is free this cycle: it either takes the new op or goes empty.
         s1_valid <= accept;
         if (accept) begin
            s1_a      <= in_a;
            s1_b      <= b_eff;
            s1_signed <= op_signed;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Compare
   // ---------------------------------------------------------------------------
   // A signed compare equals an unsigned compare after both sign bits are
   // inverted. This keeps a single magnitude comparator for both modes.
   assign cmp_a = {s1_a[WIDTH-1] ^ s1_signed, s1_a[WIDTH-2:0]};
   assign cmp_b = {s1_b[WIDTH-1] ^ s1_signed, s1_b[WIDTH-2:0]};
   assign lt    = (cmp_a < cmp_b);

   // ---------------------------------------------------------------------------
   // Stage 2 (output register)
   // ---------------------------------------------------------------------------
   // out_result is loaded only when a live op moves in. It therefore stays
   // stable during a stall. After a flush it keeps a stale, don't-care value.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= {{(WIDTH-1){1'b0}}, lt};
         end
      end
   end

endmodule

// File: tb/tb_slt_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_slt_compare_pipe
//
// Purpose:
//   Self-checking bench for slt_compare_pipe with WIDTH=16 and IMM_W=6.
//   It runs directed scenarios and then a randomized stream. Expected
//   results come from an integer-arithmetic reference model and a
//   scoreboard queue.
//
// Ports:
//   None (top-level bench).
// -----------------------------------------------------------------------------
module tb_slt_compare_pipe;

   localparam int W  = 16;
   localparam int IW = 6;

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [IW-1:0] imm;
      logic          res;
   } vec_t;

   // ---------------------------------------------------------------------------
   // Clock and reset
   // ---------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = '0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [IW-1:0] in_imm = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_result;

   always #5 clk = ~clk;

   slt_compare_pipe #(.WIDTH(W), .IMM_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   // Handshake values sampled just before the edge that step() crosses.
   logic         acc;
   logic         pop;
   logic         stall;
   logic         rdy;
   logic [W-1:0] got;

   // ---------------------------------------------------------------------------
   // Reference model: plain integer arithmetic
   // ---------------------------------------------------------------------------
   function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [IW-1:0] imm);
      longint span, ua, ub, sa, sb;
      span = longint'(1) << W;
      ua   = longint'(a);
      sa   = (ua >= span / 2) ? ua - span : ua;
      if (op[1]) begin
         sb = longint'(imm);
         if (sb >= (longint'(1) << (IW - 1))) sb = sb - (longint'(1) << IW);
         ub = (sb < 0) ? sb + span : sb;
      end else begin
         ub = longint'(b);
         sb = (ub >= span / 2) ? ub - span : ub;
      end
      if (op[0]) return (ua < ub) ? W'(1) : W'(0);
      else       return (sa < sb) ? W'(1) : W'(0);
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [IW-1:0] imm);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_imm   = imm;
   endtask

   task automatic drive_idle();
      drive(1'b0, 2'd0, '0, '0, '0);
   endtask

   // Let the driven inputs settle, sample the handshake, then cross one edge.
   task automatic step();
      #1;
      acc   = in_valid && in_ready;
      pop   = out_valid && out_ready;
      stall = out_valid && !out_ready;
      rdy   = in_ready;
      got   = out_result;
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_result !== '0) begin
         errors++;
         $display("FAIL reset_out_result: got %h expected 0", out_result);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_basic_back_to_back();
      out_ready = 1'b1;
      drive(1'b1, 2'd0, 16'd3, 16'd5, '0);
      step();
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL basic_accept0: got %b expected 1", acc);
      end
      drive(1'b1, 2'd0, 16'd7, 16'd7, '0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'd1) begin
         errors++;
         $display("FAIL basic_slt_3_5: got v=%b r=%h expected v=1 r=0001", out_valid, out_result);
      end
      drive_idle();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'd0) begin
         errors++;
         $display("FAIL basic_slt_7_7: got v=%b r=%h expected v=1 r=0000", out_valid, out_result);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drained: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_signed_unsigned();
      vec_t v[4];
      v[0] = '{2'd0, 16'hFFFF, 16'h0001, 6'h00, 1'b1};
      v[1] = '{2'd1, 16'hFFFF, 16'h0001, 6'h00, 1'b0};
      v[2] = '{2'd0, 16'h8000, 16'h7FFF, 6'h00, 1'b1};
      v[3] = '{2'd1, 16'h8000, 16'h7FFF, 6'h00, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b, v[i].imm);
         step();
         drive_idle();
         step();
         checks++;
         if (out_valid !== 1'b1 || out_result !== W'(v[i].res)) begin
            errors++;
            $display("FAIL sign_unsigned[%0d]: got v=%b r=%h expected v=1 r=%h",
                     i, out_valid, out_result, W'(v[i].res));
         end
         step();
      end
   endtask

   task automatic test_immediate();
      vec_t v[3];
      // Each in_b is chosen so that using it instead of the immediate would
      // flip the answer.
      v[0] = '{2'd2, 16'hFFFE, 16'h8000, 6'h3F, 1'b1};
      v[1] = '{2'd2, 16'h0000, 16'h7FFF, 6'h20, 1'b0};
      v[2] = '{2'd3, 16'h0005, 16'h0000, 6'h3F, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b, v[i].imm);
         step();
         drive_idle();
         step();
         checks++;
         if (out_valid !== 1'b1 || out_result !== W'(v[i].res)) begin
            errors++;
            $display("FAIL immediate[%0d]: got v=%b r=%h expected v=1 r=%h",
                     i, out_valid, out_result, W'(v[i].res));
         end
         step();
      end
   endtask

   task automatic test_stream_latency();
      logic [W-1:0] exp_r[8];
      logic [1:0]   op;
      logic [W-1:0] a, b;
      logic [IW-1:0] imm;
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            op  = 2'($urandom_range(0, 3));
            a   = W'($urandom);
            b   = W'($urandom);
            imm = IW'($urandom);
            exp_r[i] = ref_result(op, a, b, imm);
            drive(1'b1, op, a, b, imm);
         end else begin
            drive_idle();
         end
         step();
         if (i < 8) begin
            checks++;
            if (acc !== 1'b1) begin
               errors++;
               $display("FAIL stream_accept[%0d]: got %b expected 1", i, acc);
            end
         end
         if (i >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_r[i-1]) begin
               errors++;
               $display("FAIL stream_result[%0d]: got v=%b r=%h expected v=1 r=%h",
                        i - 1, out_valid, out_result, exp_r[i-1]);
            end
         end
      end
      drive_idle();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drained: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      vec_t v[4];
      int   k;
      int   r;
      v[0] = '{2'd0, 16'd3,    16'd5, 6'h00, 1'b1};
      v[1] = '{2'd0, 16'd7,    16'd7, 6'h00, 1'b0};
      v[2] = '{2'd1, 16'd1,    16'd2, 6'h00, 1'b1};
      v[3] = '{2'd2, 16'hFFFE, 16'd0, 6'h3F, 1'b1};
      k = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, v[k].op, v[k].a, v[k].b, v[k].imm);
         step();
         if (acc) k++;
         if (c >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 16'd1) begin
               errors++;
               $display("FAIL bp_stall_hold[%0d]: got v=%b r=%h expected v=1 r=0001",
                        c, out_valid, out_result);
            end
         end
      end
      checks++;
      if (k != 2) begin
         errors++;
         $display("FAIL bp_accept_count: got %0d expected 2", k);
      end
      drive(1'b1, v[k].op, v[k].a, v[k].b, v[k].imm);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready_low: got %b expected 0", in_ready);
      end
      out_ready = 1'b1;
      r = 0;
      for (int c = 0; c < 12; c++) begin
         if (k < 4) drive(1'b1, v[k].op, v[k].a, v[k].b, v[k].imm);
         else       drive_idle();
         step();
         if (acc) k++;
         if (pop) begin
            checks++;
            if (r >= 4) begin
               errors++;
               $display("FAIL bp_extra_output: got r=%h expected no output", got);
            end else if (got !== W'(v[r].res)) begin
               errors++;
               $display("FAIL bp_order[%0d]: got %h expected %h", r, got, W'(v[r].res));
            end
            r++;
         end
      end
      checks++;
      if (r != 4 || k != 4) begin
         errors++;
         $display("FAIL bp_totals: got accepted=%0d delivered=%0d expected 4 and 4", k, r);
      end
   endtask

   task automatic test_flush();
      int pops;
      out_ready = 1'b0;
      drive(1'b1, 2'd0, 16'd1, 16'd2, '0);
      step();
      drive(1'b1, 2'd1, 16'd2, 16'd9, '0);
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_filled: got v=%b expected 1", out_valid);
      end
      flush = 1'b1;
      drive(1'b1, 2'd0, 16'd4, 16'd8, '0);
      step();
      checks++;
      if (acc !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_accept: got %b expected 0", acc);
      end
      flush = 1'b0;
      drive_idle();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      pops = 0;
      repeat (4) begin
         step();
         if (pop) pops++;
      end
      checks++;
      if (pops != 0) begin
         errors++;
         $display("FAIL flush_ghost_outputs: got %0d expected 0", pops);
      end
   endtask

   task automatic test_reset_mid();
      int pops;
      out_ready = 1'b0;
      drive(1'b1, 2'd0, 16'hFFFF, 16'd0, '0);
      step();
      drive(1'b1, 2'd1, 16'd0, 16'd1, '0);
      step();
      rst = 1'b1;
      drive(1'b1, 2'd0, 16'd1, 16'd2, '0);
      step();
      checks++;
      if (acc !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_accept: got %b expected 0", acc);
      end
      checks++;
      if (out_valid !== 1'b0 || out_result !== '0) begin
         errors++;
         $display("FAIL rstmid_cleared: got v=%b r=%h expected v=0 r=0000", out_valid, out_result);
      end
      rst = 1'b0;
      drive_idle();
      out_ready = 1'b1;
      pops = 0;
      repeat (3) begin
         step();
         if (pop) pops++;
      end
      checks++;
      if (pops != 0) begin
         errors++;
         $display("FAIL rstmid_ghost_outputs: got %0d expected 0", pops);
      end
      drive(1'b1, 2'd3, 16'd5, 16'hFFFF, 6'h3F);
      step();
      drive_idle();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'd1) begin
         errors++;
         $display("FAIL rstmid_first_op: got v=%b r=%h expected v=1 r=0001", out_valid, out_result);
      end
      step();
   endtask

   task automatic test_random();
      logic [1:0]    op;
      logic [W-1:0]  a, b, held, e;
      logic [IW-1:0] imm;
      logic          exp_rdy;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         op  = 2'($urandom_range(0, 3));
         a   = W'($urandom);
         b   = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
         imm = IW'($urandom);
         if ($urandom_range(0, 7) == 0) a = W'(ref_result(2'd1, '0, '0, '0)) | 16'h8000;
         drive(1'($urandom_range(0, 3) != 0), op, a, b, imm);
         out_ready = 1'($urandom_range(0, 3) != 0);
         held = out_result;
         step();
         // The unit refuses input only when it holds two ops and keeps both.
         exp_rdy = !(exp_q.size() == 2 && !out_ready);
         checks++;
         if (rdy !== exp_rdy) begin
            errors++;
            $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, rdy, exp_rdy);
         end
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== held) begin
               errors++;
               $display("FAIL rand_stall_hold[%0d]: got v=%b r=%h expected v=1 r=%h",
                        c, out_valid, out_result, held);
            end
         end
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_unexpected_output[%0d]: got %h expected none", c, got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL rand_result[%0d]: got %h expected %h", c, got, e);
               end
            end
         end
         if (acc) exp_q.push_back(ref_result(op, a, b, imm));
      end
      drive_idle();
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_drain_extra: got %h expected none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL rand_drain_result: got %h expected %h", got, e);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_lost_ops: got %0d pending expected 0", exp_q.size());
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and final report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_basic_back_to_back();
      test_signed_unsigned();
      test_immediate();
      test_stream_latency();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
